// File: rtl/alu_chk_pkg.sv
// Shared types, opcodes and the golden ALU for the exhaustive ALU sweep checker.
package alu_chk_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   localparam int NUM_VECTORS = 1024;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   // One in-flight compare: valid, {op,A,B} tag and the golden result.
   typedef struct packed {
      logic       vld;
      logic [9:0] tag;
      logic [3:0] exp;
   } chk_ent_t;

   function automatic logic [3:0] golden_alu(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         default: return a | b;
      endcase
   endfunction

endpackage

// File: rtl/alu_chk_delay.sv
// DUT_LAT-deep delay line for compare entries; a plain wire when DUT_LAT is 0.
module alu_chk_delay
   import alu_chk_pkg::*;
#(
   parameter int DUT_LAT = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     flush,
   input  chk_ent_t in_ent,
   output chk_ent_t out_ent
);

   generate
      if (DUT_LAT == 0) begin : g_wire
         logic unused_ok;
         assign unused_ok = ^{clk, rst_n, flush};
         assign out_ent   = in_ent;
      end else begin : g_pipe
         chk_ent_t stage_q [DUT_LAT];
         chk_ent_t stage_d [DUT_LAT];

         always_comb begin
            stage_d[0] = flush ? '0 : in_ent;
            for (int i = 1; i < DUT_LAT; i++)
               stage_d[i] = flush ? '0 : stage_q[i-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DUT_LAT; i++) stage_q[i] <= '0;
            end else begin
               for (int i = 0; i < DUT_LAT; i++) stage_q[i] <= stage_d[i];
            end
         end

         assign out_ent = stage_q[DUT_LAT-1];
      end
   endgenerate

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive {op,A,B} sweep driver and golden-model checker for the 4-bit ALU.
// Optional: define ALU_CHK_STOP_ON_FAIL_EN to end the sweep after the first mismatch.
module alu_sweep_checker
   import alu_chk_pkg::*;
#(
   parameter int DUT_LAT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  dut_result,
   output logic [3:0]  vec_a,
   output logic [3:0]  vec_b,
   output logic [1:0]  vec_op,
   output logic        vec_valid,
   output logic        busy,
   output logic        done,
   output logic [10:0] mism_cnt,
   output logic        trojan_detected,
   output logic [9:0]  first_fail_vec,
   output logic [3:0]  first_fail_exp,
   output logic [3:0]  first_fail_got
);

   state_e      state_q, state_d;
   logic [9:0]  idx_q, idx_d;
   logic [2:0]  drain_q, drain_d;
   logic [10:0] mism_q, mism_d;
   logic        trojan_q, trojan_d;
   logic [9:0]  ff_vec_q, ff_vec_d;
   logic [3:0]  ff_exp_q, ff_exp_d;
   logic [3:0]  ff_got_q, ff_got_d;

   chk_ent_t push_ent, pop_ent;
   logic     run, in_sweep, stop_fire, cmp_en, mism_hit;

   assign run      = (state_q == RUN);
   assign in_sweep = (state_q == RUN) || (state_q == DRAIN);

   always_comb begin
      push_ent     = '0;
      push_ent.vld = run;
      push_ent.tag = idx_q;
      push_ent.exp = golden_alu(idx_q[7:4], idx_q[3:0], idx_q[9:8]);
   end

`ifdef ALU_CHK_STOP_ON_FAIL_EN
   // The edge after the first mismatch ends the sweep; nothing else is compared.
   assign stop_fire = trojan_q && in_sweep;
`else
   assign stop_fire = 1'b0;
`endif

   alu_chk_delay #(.DUT_LAT(DUT_LAT)) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (stop_fire),
      .in_ent  (push_ent),
      .out_ent (pop_ent)
   );

   assign cmp_en   = pop_ent.vld && in_sweep && !stop_fire;
   assign mism_hit = cmp_en && (dut_result != pop_ent.exp);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      drain_d  = drain_q;
      mism_d   = mism_q;
      trojan_d = trojan_q;
      ff_vec_d = ff_vec_q;
      ff_exp_d = ff_exp_q;
      ff_got_d = ff_got_q;

      if (mism_hit) begin
         mism_d   = mism_q + 11'd1;
         trojan_d = 1'b1;
         if (!trojan_q) begin
            ff_vec_d = pop_ent.tag;
            ff_exp_d = pop_ent.exp;
            ff_got_d = dut_result;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               idx_d    = '0;
               drain_d  = '0;
               mism_d   = '0;
               trojan_d = 1'b0;
               ff_vec_d = '0;
               ff_exp_d = '0;
               ff_got_d = '0;
            end
         end
         RUN: begin
            if (idx_q == 10'(NUM_VECTORS - 1)) begin
               state_d = (DUT_LAT == 0) ? DONE : DRAIN;
               drain_d = '0;
            end else begin
               idx_d = idx_q + 10'd1;
            end
         end
         DRAIN: begin
            if (drain_q == 3'(DUT_LAT - 1)) state_d = DONE;
            else                            drain_d = drain_q + 3'd1;
         end
         default: state_d = IDLE;
      endcase

      if (stop_fire) state_d = DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         drain_q  <= '0;
         mism_q   <= '0;
         trojan_q <= 1'b0;
         ff_vec_q <= '0;
         ff_exp_q <= '0;
         ff_got_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         drain_q  <= drain_d;
         mism_q   <= mism_d;
         trojan_q <= trojan_d;
         ff_vec_q <= ff_vec_d;
         ff_exp_q <= ff_exp_d;
         ff_got_q <= ff_got_d;
      end
   end

   assign vec_op          = idx_q[9:8];
   assign vec_a           = idx_q[7:4];
   assign vec_b           = idx_q[3:0];
   assign vec_valid       = run;
   assign busy            = in_sweep;
   assign done            = (state_q == DONE);
   assign mism_cnt        = mism_q;
   assign trojan_detected = trojan_q;
   assign first_fail_vec  = ff_vec_q;
   assign first_fail_exp  = ff_exp_q;
   assign first_fail_got  = ff_got_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench: two checkers (DUT_LAT 0 and 2) around table-driven faulty ALUs, checked against a sweep model.
module tb_alu_sweep_checker;

`ifdef ALU_CHK_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  got_tbl [1024];
   logic [3:0]  res0, res2, p1, p2;

   logic [3:0]  a0, b0, a2, b2, ffe0, ffg0, ffe2, ffg2;
   logic [1:0]  op0, op2;
   logic        vv0, vv2, busy0, busy2, done0, done2, troj0, troj2;
   logic [10:0] mism0, mism2;
   logic [9:0]  ffv0, ffv2;

   int total = 0;
   int bad   = 0;

   // Combinational faulty ALU for the zero-latency checker.
   always_comb res0 = got_tbl[{op0, a0, b0}];

   // Two-stage registered faulty ALU for the DUT_LAT=2 checker.
   always @(posedge clk) begin
      p1 <= got_tbl[{op2, a2, b2}];
      p2 <= p1;
   end
   assign res2 = p2;

   alu_sweep_checker #(.DUT_LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_result(res0),
      .vec_a(a0), .vec_b(b0), .vec_op(op0), .vec_valid(vv0), .busy(busy0), .done(done0),
      .mism_cnt(mism0), .trojan_detected(troj0), .first_fail_vec(ffv0),
      .first_fail_exp(ffe0), .first_fail_got(ffg0));

   alu_sweep_checker #(.DUT_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_result(res2),
      .vec_a(a2), .vec_b(b2), .vec_op(op2), .vec_valid(vv2), .busy(busy2), .done(done2),
      .mism_cnt(mism2), .trojan_detected(troj2), .first_fail_vec(ffv2),
      .first_fail_exp(ffe2), .first_fail_got(ffg2));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_alu(input int k);
      int op, a, b, r;
      op = (k >> 8) & 3;
      a  = (k >> 4) & 15;
      b  = k & 15;
      case (op)
         0:       r = (a + b) % 16;
         1:       r = (a - b + 16) % 16;
         2:       r = a & b;
         default: r = a | b;
      endcase
      return r[3:0];
   endfunction

   // mode 0 clean, 1 one vector forced to val, 2 bit stuck at 0, 3 sparse random corruption
   task automatic build_tbl(input int mode, input int pos, input int val);
      for (int k = 0; k < 1024; k++) begin
         got_tbl[k] = ref_alu(k);
         if (mode == 2) got_tbl[k][pos] = 1'b0;
         if (mode == 3 && ($urandom % 64) == 0)
            got_tbl[k] = got_tbl[k] ^ 4'($urandom_range(1, 15));
      end
      if (mode == 1) got_tbl[pos] = val[3:0];
   endtask

   function automatic logic [63:0] all_outs0();
      return 64'({a0, b0, op0, vv0, busy0, done0, mism0, troj0, ffv0, ffe0, ffg0});
   endfunction
   function automatic logic [63:0] all_outs2();
      return 64'({a2, b2, op2, vv2, busy2, done2, mism2, troj2, ffv2, ffe2, ffg2});
   endfunction

   task automatic run_sweep(input string name);
      int cnt, first, d0, d2, e0, e2, ecnt, n;
      cnt = 0;
      first = -1;
      for (int k = 0; k < 1024; k++)
         if (got_tbl[k] != ref_alu(k)) begin
            cnt++;
            if (first < 0) first = k;
         end
      ecnt = (STOP && cnt > 0) ? 1 : cnt;
      e0 = 1024;
      e2 = 1026;
      if (STOP && first >= 0) begin
         e0 = (first + 2 < 1024) ? first + 2 : 1024;
         e2 = (first + 4 < 1026) ? first + 4 : 1026;
      end

      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({name, ".vld_after_e0"}, {vv0, vv2, busy0, busy2}, 4'hF);
      chk({name, ".vec_after_e0"}, {op0, a0, b0, op2, a2, b2}, 20'h0);

      d0 = 0;
      d2 = 0;
      n  = 1;
      while (n <= 1200 && (d0 == 0 || d2 == 0)) begin
         if (n == 300) start = 1'b1;
         if (n == 301) start = 1'b0;
         @(posedge clk);
         #1;
         if (done0 && d0 == 0) d0 = n;
         if (done2 && d2 == 0) d2 = n;
         n++;
      end
      start = 1'b0;

      chk({name, ".done_edge0"}, d0, e0);
      chk({name, ".done_edge2"}, d2, e2);
      chk({name, ".mism0"}, mism0, ecnt);
      chk({name, ".mism2"}, mism2, ecnt);
      chk({name, ".trojan"}, {troj0, troj2}, (cnt > 0) ? 2'b11 : 2'b00);
      chk({name, ".idle_flags"}, {busy0, busy2, vv0, vv2}, 4'h0);
      if (first >= 0) begin
         chk({name, ".ffvec0"}, ffv0, first);
         chk({name, ".ffvec2"}, ffv2, first);
         chk({name, ".ffexp"}, {ffe0, ffe2}, {ref_alu(first), ref_alu(first)});
         chk({name, ".ffgot"}, {ffg0, ffg2}, {got_tbl[first], got_tbl[first]});
      end else begin
         chk({name, ".ff_clear"}, {ffv0, ffe0, ffg0, ffv2, ffe2, ffg2}, 36'h0);
      end
   endtask

   initial begin
      #1;
      chk("reset_async0", all_outs0(), 64'h0);
      chk("reset_async2", all_outs2(), 64'h0);
      build_tbl(0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_hold", all_outs0() | all_outs2(), 64'h0);

      run_sweep("clean");
      build_tbl(1, 10'h2FF, 0);
      run_sweep("and_ff");
      build_tbl(2, 3, 0);
      run_sweep("stuck3");

      // Mid-sweep reset: everything must drop immediately, then a fresh sweep runs.
      build_tbl(3, 0, 0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      chk("pre_reset_busy", {busy0, busy2}, 2'b11);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset0", all_outs0(), 64'h0);
      chk("midreset2", all_outs2(), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep("after_rst");

      for (int r = 0; r < 3; r++) begin
         int m;
         m = $urandom_range(0, 3);
         build_tbl(m, (m == 2) ? $urandom_range(0, 3) : $urandom_range(0, 1023),
                   $urandom_range(0, 15));
         run_sweep($sformatf("rand%0d_m%0d", r, m));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
